// File: rtl/nios_pkg.sv
// rtl/nios_pkg.sv - shared constants and response type for the instruction-memory responder
// Contents:
//   INSTR_W        instruction word width
//   NIOS_NOP_WORD  substitute word returned on a bad fetch address (add r0,r0,r0)
//   resp_t         one response slot: {valid, err, word}
package nios_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NIOS_NOP_WORD = 32'h0001883A;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [INSTR_W-1:0] word;
  } resp_t;

endpackage

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch-side bus between the fetch stage and the instruction memory
// Signals:
//   req_40     fetch request valid            (fetch -> memory)
//   mra_i_40   fetch byte address             (fetch -> memory)
//   flush_40   redirect, kill in-flight words (fetch -> memory)
//   busy_40    request cannot be taken        (memory -> fetch)
//   mrd_i_40   returned instruction word      (memory -> fetch)
//   rvalid_40  mrd_i_40 valid this cycle      (memory -> fetch)
//   err_40     word is the error substitute   (memory -> fetch)
// Modports: master = fetch stage, slave = responder.
interface imem_responder_if;
  import nios_pkg::*;

  logic               req_40;
  logic [31:0]        mra_i_40;
  logic               flush_40;
  logic               busy_40;
  logic [INSTR_W-1:0] mrd_i_40;
  logic               rvalid_40;
  logic               err_40;

  modport master (
    output req_40, mra_i_40, flush_40,
    input  busy_40, mrd_i_40, rvalid_40, err_40
  );

  modport slave (
    input  req_40, mra_i_40, flush_40,
    output busy_40, mrd_i_40, rvalid_40, err_40
  );

endinterface

// File: rtl/imem_responder_resp_pipe.sv
// rtl/imem_responder_resp_pipe.sv - LATENCY-deep delay line of response slots with flush
// Ports:
//   clk_40    clock, rising edge
//   rst_40    asynchronous active-high reset, empties every slot and zeroes the word
//   flush_40  synchronous kill of every slot, including the one entering this edge
//   in_resp   slot entering the line (valid=1 only for an accepted request)
//   out_resp  last slot; its word is held while no valid response arrives
module resp_pipe
  import nios_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk_40,
  input  logic  rst_40,
  input  logic  flush_40,
  input  resp_t in_resp,
  output resp_t out_resp
);

  resp_t st  [LATENCY];
  resp_t nxt [LATENCY];

  always_comb begin
    nxt[0] = in_resp;
    for (int i = 1; i < LATENCY; i++) begin
      nxt[i] = st[i-1];
    end
  end

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      for (int i = 0; i < LATENCY; i++) begin
        st[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (flush_40) begin
          st[i].valid <= 1'b0;
          st[i].err   <= 1'b0;
        end else if (i == LATENCY - 1 && !nxt[i].valid) begin
          // Output slot keeps the last word on a bubble so mrd_i_40 holds.
          st[i].valid <= 1'b0;
          st[i].err   <= 1'b0;
        end else begin
          st[i] <= nxt[i];
        end
      end
    end
  end

  assign out_resp = st[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder: program store, address decode, busy
// Ports:
//   clk_40      clock, rising edge
//   rst_40      asynchronous active-high reset (memory contents are not reset)
//   fetch       imem_responder_if.slave fetch-side bus
//   ld_we_40    preload write enable; also blocks fetch requests that cycle
//   ld_addr_40  preload word index
//   ld_data_40  preload data
module imem_responder
  import nios_pkg::*;
#(
  parameter int                 DEPTH    = 1024,
  parameter int                 ADDR_W   = 10,
  parameter int                 LATENCY  = 1,
  parameter logic [INSTR_W-1:0] NOP_WORD = NIOS_NOP_WORD
) (
  input  logic               clk_40,
  input  logic               rst_40,
  imem_responder_if.slave    fetch,
  input  logic               ld_we_40,
  input  logic [ADDR_W-1:0]  ld_addr_40,
  input  logic [INSTR_W-1:0] ld_data_40
);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  word_idx;
  logic               addr_err;
  logic               accept;
  resp_t              req_resp;
  resp_t              out_resp;

  // Preload owns the cycle, so a read never meets a write to the array.
  assign fetch.busy_40 = ld_we_40;
  assign accept        = fetch.req_40 & ~ld_we_40;

  assign word_idx = fetch.mra_i_40[ADDR_W+1:2];
  assign addr_err = (|fetch.mra_i_40[1:0]) | (|fetch.mra_i_40[31:ADDR_W+2]);

  // Combinational read so a word written at edge E is seen by an accept at E+1.
  always_comb begin
    req_resp       = '0;
    req_resp.valid = accept;
    req_resp.err   = addr_err;
    req_resp.word  = addr_err ? NOP_WORD : mem[word_idx];
  end

  always_ff @(posedge clk_40) begin
    if (ld_we_40) begin
      mem[ld_addr_40] <= ld_data_40;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk_40   (clk_40),
    .rst_40   (rst_40),
    .flush_40 (fetch.flush_40),
    .in_resp  (req_resp),
    .out_resp (out_resp)
  );

  assign fetch.rvalid_40 = out_resp.valid;
  assign fetch.err_40    = out_resp.err;
  assign fetch.mrd_i_40  = out_resp.word;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder at LATENCY 2 and 3
module tb_imem_responder;

  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0001883A;
  localparam int          MAXE   = 8192;

  logic        clk_40 = 1'b0;
  logic        rst_40 = 1'b1;
  logic        req     = 1'b0;
  logic [31:0] addr    = '0;
  logic        flush   = 1'b0;
  logic        ld_we   = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk_40 = ~clk_40;

  imem_responder_if bus2 ();
  imem_responder_if bus3 ();

  assign bus2.req_40   = req;
  assign bus2.mra_i_40 = addr;
  assign bus2.flush_40 = flush;
  assign bus3.req_40   = req;
  assign bus3.mra_i_40 = addr;
  assign bus3.flush_40 = flush;

  imem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(2), .NOP_WORD(NOP)) dut2 (
    .clk_40 (clk_40), .rst_40 (rst_40), .fetch (bus2),
    .ld_we_40 (ld_we), .ld_addr_40 (ld_addr), .ld_data_40 (ld_data)
  );

  imem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(3), .NOP_WORD(NOP)) dut3 (
    .clk_40 (clk_40), .rst_40 (rst_40), .fetch (bus3),
    .ld_we_40 (ld_we), .ld_addr_40 (ld_addr), .ld_data_40 (ld_data)
  );

  // Reference model: a timeline of edges. Each accepted request is recorded
  // against the edge that took it; a response for latency L is due at edge
  // N+L-1 unless a flush landed on any edge N..N+L-1 or a reset came after N.
  bit          acc_v [MAXE];
  logic [31:0] acc_w [MAXE];
  bit          acc_e [MAXE];
  bit          fl    [MAXE];
  logic [31:0] shadow [DEPTH];
  int          edge_n    = 0;
  int          kill_upto = 0;
  bit          exp_v [2] = '{0, 0};
  logic [31:0] exp_w [2] = '{0, 0};
  bit          exp_e [2] = '{0, 0};
  int          lat_of [2] = '{2, 3};

  always @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      kill_upto = edge_n;
      for (int d = 0; d < 2; d++) begin
        exp_v[d] = 0;
        exp_e[d] = 0;
        exp_w[d] = '0;
      end
    end else begin
      edge_n++;
      acc_v[edge_n] = req && !ld_we;
      acc_e[edge_n] = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
      acc_w[edge_n] = acc_e[edge_n] ? NOP : shadow[addr[11:2]];
      fl[edge_n]    = flush;
      if (ld_we) shadow[ld_addr] = ld_data;
      for (int d = 0; d < 2; d++) begin
        int n;
        bit alive;
        n = edge_n - lat_of[d] + 1;
        alive = (n >= 1) && (n > kill_upto) && acc_v[n];
        for (int j = (n < 1 ? 1 : n); j <= edge_n; j++) begin
          if (fl[j]) alive = 0;
        end
        if (alive) begin
          exp_v[d] = 1;
          exp_w[d] = acc_w[n];
          exp_e[d] = acc_e[n];
        end else begin
          exp_v[d] = 0;
          exp_e[d] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk_40) begin
    #1;
    chk("rvalid2", 32'(bus2.rvalid_40), 32'(exp_v[0]));
    chk("err2",    32'(bus2.err_40),    32'(exp_e[0]));
    chk("mrd2",    bus2.mrd_i_40,       exp_w[0]);
    chk("busy2",   32'(bus2.busy_40),   32'(ld_we));
    chk("rvalid3", 32'(bus3.rvalid_40), 32'(exp_v[1]));
    chk("err3",    32'(bus3.err_40),    32'(exp_e[1]));
    chk("mrd3",    bus3.mrd_i_40,       exp_w[1]);
    chk("busy3",   32'(bus3.busy_40),   32'(ld_we));
  end

  task automatic cyc(input bit r, input logic [31:0] a, input bit f = 0,
                     input bit w = 0, input logic [9:0] wa = '0, input logic [31:0] wd = '0);
    @(negedge clk_40);
    req = r; addr = a; flush = f; ld_we = w; ld_addr = wa; ld_data = wd;
    @(posedge clk_40);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk_40);
    #2;
    chk("reset_rvalid", 32'(bus2.rvalid_40), 32'd0);
    chk("reset_err",    32'(bus2.err_40),    32'd0);
    chk("reset_mrd",    bus3.mrd_i_40,       32'd0);
    @(negedge clk_40);
    rst_40 = 1'b0;

    // Preload the whole image; first four words are known constants.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      case (i)
        0: d = 32'h11111111;
        1: d = 32'h22222222;
        2: d = 32'h33333333;
        3: d = 32'h44444444;
        default: d = $urandom;
      endcase
      cyc(0, 0, 0, 1, 10'(i), d);
    end

    // Back-to-back reads, latency 2.
    cyc(1, 32'h0); chk("b2b_lat_gap", 32'(bus2.rvalid_40), 32'd0);
    cyc(1, 32'h4); chk("b2b_v0", 32'(bus2.rvalid_40), 32'd1); chk("b2b_w0", bus2.mrd_i_40, 32'h11111111);
    cyc(1, 32'h8); chk("b2b_w1", bus2.mrd_i_40, 32'h22222222);
    cyc(1, 32'hC); chk("b2b_w2", bus2.mrd_i_40, 32'h33333333);
    cyc(0, 32'h0); chk("b2b_w3", bus2.mrd_i_40, 32'h44444444); chk("b2b_e3", 32'(bus2.err_40), 32'd0);
    cyc(0, 32'h0); chk("b2b_end", 32'(bus2.rvalid_40), 32'd0); chk("hold_w", bus2.mrd_i_40, 32'h44444444);

    // Misaligned then out-of-range.
    cyc(1, 32'h6);
    cyc(1, 32'h1000); chk("mis_v", 32'(bus2.rvalid_40), 32'd1); chk("mis_w", bus2.mrd_i_40, NOP);
    chk("mis_e", 32'(bus2.err_40), 32'd1);
    cyc(0, 32'h0); chk("oor_w", bus2.mrd_i_40, NOP); chk("oor_e", 32'(bus2.err_40), 32'd1);
    cyc(0, 32'h0); chk("err_idle", 32'(bus2.err_40), 32'd0);

    // Preload while a request is held.
    cyc(1, 32'h4, 0, 1, 10'd1, 32'hCAFEF00D); chk("busy_on", 32'(bus2.busy_40), 32'd1);
    cyc(1, 32'h4); chk("busy_ignored", 32'(bus2.rvalid_40), 32'd0);
    cyc(0, 32'h0); chk("new_data", bus2.mrd_i_40, 32'hCAFEF00D);
    repeat (3) cyc(0, 32'h0);

    // Flush with three requests in flight, latency 3.
    cyc(1, 32'h0);
    cyc(1, 32'h4);
    cyc(1, 32'h8, 1); chk("flush_v3", 32'(bus3.rvalid_40), 32'd0); chk("flush_v2", 32'(bus2.rvalid_40), 32'd0);
    cyc(1, 32'hC);    chk("flush_v3b", 32'(bus3.rvalid_40), 32'd0);
    cyc(0, 32'h0);    chk("flush_v3c", 32'(bus3.rvalid_40), 32'd0);
    cyc(0, 32'h0);    chk("post_flush_v", 32'(bus3.rvalid_40), 32'd1);
    chk("post_flush_w", bus3.mrd_i_40, 32'h44444444);
    repeat (3) cyc(0, 32'h0);

    // Asynchronous reset with responses in flight.
    cyc(1, 32'h0);
    cyc(1, 32'h4); chk("pre_rst_v", 32'(bus2.rvalid_40), 32'd1);
    #2;
    rst_40 = 1'b1;
    #1;
    chk("rst_v2", 32'(bus2.rvalid_40), 32'd0);
    chk("rst_w2", bus2.mrd_i_40, 32'd0);
    chk("rst_v3", 32'(bus3.rvalid_40), 32'd0);
    cyc(0, 32'h0);
    cyc(0, 32'h0);
    @(negedge clk_40);
    rst_40 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h0);
      chk("no_stale2", 32'(bus2.rvalid_40), 32'd0);
      chk("no_stale3", 32'(bus3.rvalid_40), 32'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      if (kind == 9) a = a | (32'd1 << $urandom_range(12, 31));
      cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) == 0, 10'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    repeat (6) cyc(0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the far end of the fetch interface.
- Accepts byte addresses from the fetch stage on mra_i_40 and returns 32-bit instruction words on mrd_i_40 after a fixed, parameterised latency.
- Handles misaligned and out-of-range addresses, flushes in-flight responses on redirect, and exposes a preload port for the program image.
- Sits between the fetch stage and the on-chip program store in the Nios II-style pipeline.

Parameters:
- DEPTH, 1024: number of 32-bit instruction words stored.
- ADDR_W, 10: word-index width; must equal log2(DEPTH).
- LATENCY, 1: cycles from accepted request to rvalid_40; legal range 1..4.
- NOP_WORD, 32'h0001883A: word returned on error (Nios II nop, add r0,r0,r0).

Ports:
- clk_40  in  1  single system clock, rising edge.
- rst_40  in  1  reset, asynchronous, active-high.
- req_40  in  1  fetch request valid.
- mra_i_40  in  32  fetch byte address.
- busy_40  out  1  responder cannot accept a request this cycle.
- flush_40  in  1  redirect; kill all in-flight responses.
- mrd_i_40  out  32  instruction word returned.
- rvalid_40  out  1  mrd_i_40 valid this cycle.
- err_40  out  1  returned word is error substitute; qualified by rvalid_40.
- ld_we_40  in  1  preload write enable.
- ld_addr_40  in  ADDR_W  preload word index.
- ld_data_40  in  32  preload data.

Behaviour:
- Reset (async, immediate): rvalid_40=0, err_40=0, mrd_i_40=0, all pipeline valid bits cleared. Memory array is not reset.
- Reset mid-operation discards all in-flight responses. The first response after release requires a new request.
- busy_40 = ld_we_40 (combinational).
  - A request is accepted only when req_40=1 and busy_40=0.
  - A request during busy is ignored. Fetch holds req_40 and mra_i_40 until busy_40 drops.
- Accepted request at edge N: response appears with rvalid_40=1 in the cycle after edge N+LATENCY-1.
  - LATENCY=1 gives a registered output one cycle after acceptance.
- Throughput is one request per cycle, fully pipelined. Responses return in request order.
- Address decode:
  - word index = mra_i_40[ADDR_W+1:2].
  - Error if mra_i_40[1:0] != 0, or if mra_i_40[31:ADDR_W+2] != 0.
  - On error: mrd_i_40=NOP_WORD and err_40=1, with the same latency as a normal read.
- Non-error response: mrd_i_40 = mem[word index], err_40=0.
- When rvalid_40=0, mrd_i_40 holds its last value and err_40=0.
- flush_40=1 at edge E:
  - Clears every pipeline valid bit, including any request accepted at edge E.
  - rvalid_40=0 in the cycle after E.
  - A request presented in the cycle after E is accepted normally.
- Preload: ld_we_40=1 at edge E writes mem[ld_addr_40]=ld_data_40. The write is visible to any request accepted at edge E+1 or later.
- No read/write collision is possible, because requests are blocked while ld_we_40=1.
- Pipeline states per stage: EMPTY or FULL(word, err). Transitions on accept, advance and flush. There is no other FSM.

Decomposition:
- Package nios_pkg:
  - NOP_WORD constant.
  - Instruction width constant (32).
  - Response struct type {valid, err, word}.
- One sub-module, resp_pipe: a LATENCY-deep delay line of the response struct with synchronous flush and async reset.
- The top level keeps the memory array, address decode and busy logic.

Test Plan:
- Preload mem[0..3]=32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; issue back-to-back requests at 0x0, 0x4, 0x8, 0xC with LATENCY=2 -> four consecutive rvalid_40 cycles, the first 2 cycles after the first accept, returning those four words in order with err_40=0.
- Request at 0x6 (misaligned), then at 0x1000 with DEPTH=1024 (out of range) -> each returns 32'h0001883A with err_40=1.
- Assert ld_we_40 with req_40 held at 0x4 -> busy_40=1 and no response for that cycle; drop ld_we_40 -> request accepted and the newly written data is returned.
- LATENCY=3: three requests in flight, then pulse flush_40 -> rvalid_40 stays 0; the next request after flush returns normally 3 cycles later.
- Assert rst_40 asynchronously between edges with two responses in flight -> rvalid_40 falls immediately and mrd_i_40=0; after release, no stale response appears.
